keypad_entry: RTL and testbench
===============================

# keypad_entry

4x4 matrix keypad scanner with debounce and a 4-digit BCD entry register, the input-side counterpart of the 4-digit counter/7-segment display path. It drives keypad columns, samples rows, accepts one debounced key per press, and shifts decimal digits into units/tens/hundreds/thousands registers. Those registers feed the same per-digit BCD-to-7-segment decoders the display path uses, or a preset/compare input of the counter chain.

## Interface
- SCAN_DIV, 1000: clock cycles per column slot; minimum 4.
- DEBOUNCE, 4: consecutive identical frames required to accept a press or a release; range 1..15.
- iClk  in  1  system clock.
- iRst  in  1  asynchronous, active-low reset.
- iRow  in  4  keypad rows, active-low, externally pulled up, asynchronous to iClk.
- oCol  out  4  column drive, active-low, exactly one column low at a time.
- oKey  out  4  code of the last accepted key.
- oKeyValid  out  1  one-cycle pulse per accepted key.
- oEnter  out  1  one-cycle pulse when '#' is accepted.
- oD1, oD2, oD3, oD4  out  4 each  BCD digits: units, tens, hundreds, thousands.

## Operation
- Key map, row r top to bottom, column c left to right:
  - Row 0: 1 2 3 A
  - Row 1: 4 5 6 B
  - Row 2: 7 8 9 C
  - Row 3: * 0 # D
- Key codes: digits 0x0–0x9, A–D 0xA–0xD, * 0xE, # 0xF.
- Row synchronisation: iRow passes through a 2-flop synchronizer.
- Column scan: oCol rotates 1110 → 1101 → 1011 → 0111 → 1110.
  - Each column stays active for SCAN_DIV cycles (one slot).
  - Rows are sampled at slot count SCAN_DIV-1.
  - Four slots make one frame.
- Frame result: exactly one active key gives that code; zero keys gives NONE. Two or more keys also give NONE (ghosting rejection).
- Debounce FSM, evaluated once per frame end:
  - IDLE: a key result loads it as candidate, count=1, go to PRESS.
  - PRESS, same code: count+1. When count reaches DEBOUNCE, accept and go to HELD. With DEBOUNCE=1, acceptance happens on the first frame.
  - PRESS, different code: restart count=1 with the new candidate.
  - PRESS, NONE: go to IDLE.
  - HELD, NONE: count=1, go to RELEASE. Any key result in HELD stays in HELD and is not accepted.
  - RELEASE, NONE: count+1. When count reaches DEBOUNCE, go to IDLE.
  - RELEASE, any key result: return to HELD with no new accept.
- Accept action, all registered in one cycle:
  - oKey ← code; oKeyValid pulses.
  - Digit 0–9: oD4←oD3, oD3←oD2, oD2←oD1, oD1←code. The old thousands digit is discarded.
  - *: all digits ← 0.
  - #: oEnter pulses; digits unchanged.
  - A–C: no digit effect.
  - D: see Configuration.
- No auto-repeat; exactly one accept per debounced press.

## Timing
- Reset values:
  - oCol=1110; scan counters 0; state IDLE; count 0.
  - oKey=0; oKeyValid=0; oEnter=0; oD1–oD4=0.
- Frame length is 4·SCAN_DIV cycles. Minimum press-to-accept time is DEBOUNCE frames.
- oKeyValid and oEnter are asserted on the cycle after the final frame's last sample. Digits and oKey change on that same edge.
- Row sampling at slot end leaves at least 2 cycles for the synchronizer after the column switch; SCAN_DIV ≥ 4 guarantees this.
- Reset mid-operation clears everything immediately. A key still held after reset deasserts is accepted again after DEBOUNCE frames.
- Scanning is free-running and never stalls; there is no output handshake.

## Configuration
- KEYPAD_BACKSPACE_EN defined: accepting D performs backspace.
  - oD1←oD2, oD2←oD3, oD3←oD4, oD4←0.
  - oKeyValid still pulses with oKey=0xD.
- KEYPAD_BACKSPACE_EN undefined: D behaves like A–C (pulse only, no digit change).

## Structure
- Package keypad_pkg holds:
  - key code constants KEY_A…KEY_D, KEY_STAR=4'hE, KEY_HASH=4'hF, and the NONE marker;
  - the debounce state enumeration (IDLE, PRESS, HELD, RELEASE);
  - the row/column → code lookup function.
- Sub-module keypad_scanner: column rotation, row synchronizer, frame decode. It outputs the raw code, a NONE flag and a one-cycle frame-done strobe.
- The top level keeps the debounce FSM and the digit register.

## Test plan
Bench uses SCAN_DIV=4 and DEBOUNCE=3, so one frame is 16 cycles.
- Reset deasserted: oCol=1110, then cycles 1101 / 1011 / 0111 every 4 cycles; oD4..oD1=0000; no pulses.
- Hold '5' (row 1, col 1) for 10 frames, then release: exactly one oKeyValid, oKey=5, oD1=5. No further pulse until release plus 3 quiet frames.
- Press and release 1,2,3,4,5 in sequence: oD4..oD1=2345. Then '*': 0000. Then '#': one oEnter pulse, digits unchanged.
- Press '7' with 2 frames of bounce (alternating with NONE) before becoming stable: exactly one accept, oD1=7. A release glitch of 1 frame during the hold gives no second accept.
- Press '1' and '2' simultaneously for 10 frames: no oKeyValid. Release '2' while keeping '1': accept '1' after 3 frames.
- With digits 1234, press D:
  - macro defined: oD4..oD1=0123, oKey=0xD;
  - macro undefined: digits stay 1234, oKeyValid pulses.
- Assert iRst mid-hold of '9': outputs return to reset values. '9' is re-accepted 3 frames after reset release.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: key codes, NONE marker, debounce state constants and the
// row/column to key-code lookup shared by the keypad scanner and entry logic.
package keypad_pkg;

   // Non-digit key codes; digits use their own value 0x0..0x9
   localparam logic [3:0] KEY_A    = 4'hA;
   localparam logic [3:0] KEY_B    = 4'hB;
   localparam logic [3:0] KEY_C    = 4'hC;
   localparam logic [3:0] KEY_D    = 4'hD;
   localparam logic [3:0] KEY_STAR = 4'hE;
   localparam logic [3:0] KEY_HASH = 4'hF;

   // Frame result "no single key": lies outside the 4-bit code space
   localparam logic [4:0] KEY_NONE = 5'h10;

   // Debounce state enumeration
   typedef logic [1:0] debState_t;
   localparam debState_t ST_IDLE    = 2'd0;
   localparam debState_t ST_PRESS   = 2'd1;
   localparam debState_t ST_HELD    = 2'd2;
   localparam debState_t ST_RELEASE = 2'd3;

   // Row (top to bottom) and column (left to right) to key code
   function automatic logic [3:0] keyLookup(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] code;
      case ({row, col})
         4'h0: code = 4'h1;
         4'h1: code = 4'h2;
         4'h2: code = 4'h3;
         4'h3: code = KEY_A;
         4'h4: code = 4'h4;
         4'h5: code = 4'h5;
         4'h6: code = 4'h6;
         4'h7: code = KEY_B;
         4'h8: code = 4'h7;
         4'h9: code = 4'h8;
         4'hA: code = 4'h9;
         4'hB: code = KEY_C;
         4'hC: code = KEY_STAR;
         4'hD: code = 4'h0;
         4'hE: code = KEY_HASH;
         default: code = KEY_D;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/keypad_scanner.sv
// keypad_scanner: rotates the active-low column drive, synchronises the rows,
// samples them at the end of each column slot and reduces a four-slot frame to
// a single key code (or NONE when zero or several keys are seen).
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV = 1000
) (
   input  logic       iClk,
   input  logic       iRst,
   input  logic [3:0] iRow,
   output logic [3:0] oCol,
   output logic [3:0] oCode,
   output logic       oNone,
   output logic       oFrameDone
);

   localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

   logic [CW-1:0] slotCnt;
   logic [1:0]    colIdx;
   logic [3:0]    rowMeta;
   logic [3:0]    rowSync;
   logic [1:0]    accCnt;    // keys seen so far in this frame, saturating at 2
   logic [3:0]    accCode;
   logic          slotEnd;
   logic [2:0]    hitCnt;
   logic [1:0]    hitRow;
   logic [2:0]    sumCnt;
   logic [1:0]    nextCnt;
   logic [3:0]    nextCode;

   assign slotEnd = (slotCnt == CW'(SCAN_DIV - 1));

   // Count pressed rows in the current column and remember which one
   always_comb begin
      hitCnt = '0;
      hitRow = '0;
      for (int r = 0; r < 4; r++) begin
         if (!rowSync[r]) begin
            hitCnt = hitCnt + 3'd1;
            hitRow = 2'(r);
         end
      end
   end

   // Fold the current column sample into the frame tally
   always_comb begin
      sumCnt   = {1'b0, accCnt} + hitCnt;
      nextCnt  = (sumCnt >= 3'd2) ? 2'd2 : sumCnt[1:0];
      nextCode = (hitCnt == 3'd1) ? keyLookup(hitRow, colIdx) : accCode;
   end

   // Frame result is presented on the cycle of the last column's sample
   assign oFrameDone = slotEnd && (colIdx == 2'd3);
   assign oNone      = (nextCnt != 2'd1);
   assign oCode      = nextCode;

   // Two-flop synchroniser for the asynchronous row inputs (idle high)
   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         rowMeta <= 4'hF;
         rowSync <= 4'hF;
      end else begin
         rowMeta <= iRow;
         rowSync <= rowMeta;
      end
   end

   // Slot counter, column rotation and per-frame key tally
   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         slotCnt <= '0;
         colIdx  <= '0;
         oCol    <= 4'b1110;
         accCnt  <= '0;
         accCode <= '0;
      end else if (slotEnd) begin
         slotCnt <= '0;
         colIdx  <= colIdx + 2'd1;
         oCol    <= {oCol[2:0], oCol[3]};
         if (colIdx == 2'd3) begin
            accCnt  <= '0;
            accCode <= '0;
         end else begin
            accCnt  <= nextCnt;
            accCode <= nextCode;
         end
      end else begin
         slotCnt <= slotCnt + 1'b1;
      end
   end

endmodule

// File: rtl/keypad_entry.sv
// keypad_entry: 4x4 keypad scanner with per-frame debounce and a 4-digit BCD
// entry register (units oD1 .. thousands oD4). Build option:
// KEYPAD_BACKSPACE_EN turns the D key into a backspace on the digit register.
module keypad_entry
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV = 1000,
   parameter int DEBOUNCE = 4
) (
   input  logic       iClk,
   input  logic       iRst,
   input  logic [3:0] iRow,
   output logic [3:0] oCol,
   output logic [3:0] oKey,
   output logic       oKeyValid,
   output logic       oEnter,
   output logic [3:0] oD1,
   output logic [3:0] oD2,
   output logic [3:0] oD3,
   output logic [3:0] oD4
);

   localparam logic [3:0] DEB = 4'(DEBOUNCE);

   logic [3:0] rawCode;
   logic       rawNone;
   logic       frameDone;
   logic [4:0] frameRes;
   logic       isNone;

   debState_t  state;
   debState_t  stateNext;
   logic [3:0] cnt;
   logic [3:0] cntNext;
   logic [3:0] cntInc;
   logic [3:0] cand;
   logic [3:0] candNext;
   logic       accept;
   logic [3:0] acceptCode;

   keypad_scanner #(.SCAN_DIV(SCAN_DIV)) scanner (
      .iClk      (iClk),
      .iRst      (iRst),
      .iRow      (iRow),
      .oCol      (oCol),
      .oCode     (rawCode),
      .oNone     (rawNone),
      .oFrameDone(frameDone)
   );

   assign frameRes = rawNone ? KEY_NONE : {1'b0, rawCode};
   assign isNone   = (frameRes == KEY_NONE);
   assign cntInc   = cnt + 4'd1;

   // Debounce decision, taken only at the end of each frame
   always_comb begin
      stateNext  = state;
      cntNext    = cnt;
      candNext   = cand;
      accept     = 1'b0;
      acceptCode = cand;
      if (frameDone) begin
         case (state)
            ST_IDLE: begin
               if (!isNone) begin
                  candNext = rawCode;
                  cntNext  = 4'd1;
                  if (DEB == 4'd1) begin
                     accept     = 1'b1;
                     acceptCode = rawCode;
                     stateNext  = ST_HELD;
                  end else begin
                     stateNext = ST_PRESS;
                  end
               end
            end
            ST_PRESS: begin
               if (isNone) begin
                  cntNext   = 4'd0;
                  stateNext = ST_IDLE;
               end else if (rawCode == cand) begin
                  cntNext = cntInc;
                  if (cntInc == DEB) begin
                     accept    = 1'b1;
                     stateNext = ST_HELD;
                  end
               end else begin
                  candNext = rawCode;
                  cntNext  = 4'd1;
               end
            end
            ST_HELD: begin
               if (isNone) begin
                  cntNext   = 4'd1;
                  stateNext = (DEB == 4'd1) ? ST_IDLE : ST_RELEASE;
               end
            end
            default: begin
               if (isNone) begin
                  cntNext = cntInc;
                  if (cntInc == DEB) begin
                     cntNext   = 4'd0;
                     stateNext = ST_IDLE;
                  end
               end else begin
                  stateNext = ST_HELD;
               end
            end
         endcase
      end
   end

   // Debounce state registers
   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         state <= ST_IDLE;
         cnt   <= '0;
         cand  <= '0;
      end else begin
         state <= stateNext;
         cnt   <= cntNext;
         cand  <= candNext;
      end
   end

   // Accept action: key code, pulses and the digit register
   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         oKey      <= '0;
         oKeyValid <= 1'b0;
         oEnter    <= 1'b0;
         oD1       <= '0;
         oD2       <= '0;
         oD3       <= '0;
         oD4       <= '0;
      end else begin
         oKeyValid <= 1'b0;
         oEnter    <= 1'b0;
         if (accept) begin
            oKey      <= acceptCode;
            oKeyValid <= 1'b1;
            case (acceptCode)
               KEY_STAR: begin
                  oD1 <= '0;
                  oD2 <= '0;
                  oD3 <= '0;
                  oD4 <= '0;
               end
               KEY_HASH: oEnter <= 1'b1;
               KEY_D: begin
`ifdef KEYPAD_BACKSPACE_EN
                  oD1 <= oD2;
                  oD2 <= oD3;
                  oD3 <= oD4;
                  oD4 <= '0;
`else
                  // D is a plain function key: pulse only
`endif
               end
               KEY_A, KEY_B, KEY_C: begin
                  // Function keys: pulse only
               end
               default: begin
                  // Digit 0..9 shifts in at the units position
                  oD4 <= oD3;
                  oD3 <= oD2;
                  oD2 <= oD1;
                  oD1 <= acceptCode;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_keypad_entry.sv
// tb_keypad_entry: frame-aligned keypad stimulus with a run-length reference
// model of debounce and an arithmetic model of the 4-digit entry value.
module tb_keypad_entry;

   localparam int SCAN_DIV = 4;
   localparam int DEBOUNCE = 3;
   localparam int FRAME    = 4 * SCAN_DIV;
`ifdef KEYPAD_BACKSPACE_EN
   localparam bit BACKSPACE = 1'b1;
   localparam logic [15:0] DIGITS_AFTER_D = 16'h0123;
`else
   localparam bit BACKSPACE = 1'b0;
   localparam logic [15:0] DIGITS_AFTER_D = 16'h1234;
`endif

   // Key masks: bit index row*4 + col
   localparam logic [15:0] K1 = 16'h0001, K2 = 16'h0002, K3 = 16'h0004;
   localparam logic [15:0] K4 = 16'h0010, K5 = 16'h0020, K7 = 16'h0100;
   localparam logic [15:0] K9 = 16'h0400, KSTAR = 16'h1000, KHASH = 16'h4000;
   localparam logic [15:0] KD = 16'h8000, KNONE = 16'h0000;

   logic       iClk = 1'b0;
   logic       iRst = 1'b0;
   logic [3:0] iRow;
   logic [3:0] oCol, oKey, oD1, oD2, oD3, oD4;
   logic       oKeyValid, oEnter;
   logic [15:0] keys = '0;

   int passed = 0;
   int total  = 0;

   // Reference model state
   int         runRes;
   int         runLen;
   bit         held;
   int         val;
   logic [3:0] lastKey;
   int         segPulses;
   int         segEnters;

   logic [3:0] keyMap [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                               4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};

   typedef struct {
      logic [15:0] mask;
      int          frames;
      int          pulses;
      int          enters;
      logic [3:0]  key;
      logic [15:0] digits;
   } seg_t;
   seg_t segs[$];

   keypad_entry #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
      .iClk     (iClk),
      .iRst     (iRst),
      .iRow     (iRow),
      .oCol     (oCol),
      .oKey     (oKey),
      .oKeyValid(oKeyValid),
      .oEnter   (oEnter),
      .oD1      (oD1),
      .oD2      (oD2),
      .oD3      (oD3),
      .oD4      (oD4)
   );

   always #5 iClk = ~iClk;

   // Passive keypad: a pressed key pulls its row low while its column is driven
   always_comb begin
      iRow = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && !oCol[c]) iRow[r] = 1'b0;
   end

   function automatic logic [15:0] bcd(input int v);
      return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      else passed++;
   endtask

   task automatic modelReset();
      runRes  = -2;
      runLen  = 0;
      held    = 1'b0;
      val     = 0;
      lastKey = 4'h0;
   endtask

   task automatic addSeg(input logic [15:0] m, input int f, input int p, input int e,
                         input logic [3:0] k, input logic [15:0] d);
      seg_t s;
      s.mask = m; s.frames = f; s.pulses = p; s.enters = e; s.key = k; s.digits = d;
      segs.push_back(s);
   endtask

   // Hold one key pattern for a whole frame and compare against the model
   task automatic runFrame(input logic [15:0] mask);
      int nk, code, res, early;
      bit expAcc, expEnt;
      logic v16, e16;
      logic [3:0] expCol;
      keys = mask;
      nk = 0;
      code = 0;
      for (int b = 0; b < 16; b++)
         if (mask[b]) begin nk++; code = int'(keyMap[b]); end
      res = (nk == 1) ? code : -1;
      if (res == runRes) runLen++;
      else begin runRes = res; runLen = 1; end
      expAcc = 1'b0;
      expEnt = 1'b0;
      if (!held && res >= 0 && runLen == DEBOUNCE) begin
         held    = 1'b1;
         expAcc  = 1'b1;
         lastKey = 4'(res);
         expEnt  = (res == 15);
         if (res <= 9) val = (val * 10 + res) % 10000;
         else if (res == 14) val = 0;
         else if (res == 13 && BACKSPACE) val = val / 10;
      end else if (held && res < 0 && runLen == DEBOUNCE) begin
         held = 1'b0;
      end
      early = 0;
      v16 = 1'b0;
      e16 = 1'b0;
      for (int i = 1; i <= FRAME; i++) begin
         @(posedge iClk);
         #1;
         expCol = ~(4'b0001 << ((i % FRAME) / SCAN_DIV));
         check("col", oCol, expCol);
         if (i < FRAME) early += int'(oKeyValid) + int'(oEnter);
         else begin v16 = oKeyValid; e16 = oEnter; end
      end
      check("early_pulse", early, 0);
      check("valid", v16, expAcc);
      check("enter", e16, expEnt);
      check("key", oKey, lastKey);
      check("digits", {oD4, oD3, oD2, oD1}, bcd(val));
      segPulses += int'(v16);
      segEnters += int'(e16);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int kind, nfr, a, b;
      logic [15:0] mask;

      // Scripted segments: {mask, frames, pulses, enters, key after, digits after}
      addSeg(KNONE, 2, 0, 0, 4'h0, 16'h0000);
      addSeg(K5, 10, 1, 0, 4'h5, 16'h0005);
      addSeg(KNONE, 3, 0, 0, 4'h5, 16'h0005);
      addSeg(K1, 3, 1, 0, 4'h1, 16'h0051);    addSeg(KNONE, 3, 0, 0, 4'h1, 16'h0051);
      addSeg(K2, 3, 1, 0, 4'h2, 16'h0512);    addSeg(KNONE, 3, 0, 0, 4'h2, 16'h0512);
      addSeg(K3, 3, 1, 0, 4'h3, 16'h5123);    addSeg(KNONE, 3, 0, 0, 4'h3, 16'h5123);
      addSeg(K4, 3, 1, 0, 4'h4, 16'h1234);    addSeg(KNONE, 3, 0, 0, 4'h4, 16'h1234);
      addSeg(K5, 3, 1, 0, 4'h5, 16'h2345);    addSeg(KNONE, 3, 0, 0, 4'h5, 16'h2345);
      addSeg(KHASH, 3, 1, 1, 4'hF, 16'h2345); addSeg(KNONE, 3, 0, 0, 4'hF, 16'h2345);
      addSeg(KSTAR, 3, 1, 0, 4'hE, 16'h0000); addSeg(KNONE, 3, 0, 0, 4'hE, 16'h0000);
      addSeg(KHASH, 3, 1, 1, 4'hF, 16'h0000); addSeg(KNONE, 3, 0, 0, 4'hF, 16'h0000);
      // Bouncing '7', then a one-frame release glitch while held
      addSeg(K7, 1, 0, 0, 4'hF, 16'h0000);    addSeg(KNONE, 1, 0, 0, 4'hF, 16'h0000);
      addSeg(K7, 1, 0, 0, 4'hF, 16'h0000);    addSeg(KNONE, 1, 0, 0, 4'hF, 16'h0000);
      addSeg(K7, 5, 1, 0, 4'h7, 16'h0007);    addSeg(KNONE, 1, 0, 0, 4'h7, 16'h0007);
      addSeg(K7, 3, 0, 0, 4'h7, 16'h0007);    addSeg(KNONE, 3, 0, 0, 4'h7, 16'h0007);
      // Ghosting: '1'+'2' together rejected, then '1' alone accepted
      addSeg(K1 | K2, 10, 0, 0, 4'h7, 16'h0007);
      addSeg(K1, 3, 1, 0, 4'h1, 16'h0071);    addSeg(KNONE, 3, 0, 0, 4'h1, 16'h0071);
      // Build 1234, then D
      addSeg(KSTAR, 3, 1, 0, 4'hE, 16'h0000); addSeg(KNONE, 3, 0, 0, 4'hE, 16'h0000);
      addSeg(K1, 3, 1, 0, 4'h1, 16'h0001);    addSeg(KNONE, 3, 0, 0, 4'h1, 16'h0001);
      addSeg(K2, 3, 1, 0, 4'h2, 16'h0012);    addSeg(KNONE, 3, 0, 0, 4'h2, 16'h0012);
      addSeg(K3, 3, 1, 0, 4'h3, 16'h0123);    addSeg(KNONE, 3, 0, 0, 4'h3, 16'h0123);
      addSeg(K4, 3, 1, 0, 4'h4, 16'h1234);    addSeg(KNONE, 3, 0, 0, 4'h4, 16'h1234);
      addSeg(KD, 3, 1, 0, 4'hD, DIGITS_AFTER_D);
      addSeg(KNONE, 3, 0, 0, 4'hD, DIGITS_AFTER_D);

      // Reset state
      modelReset();
      iRst = 1'b0;
      keys = '0;
      repeat (3) @(posedge iClk);
      #1;
      check("rst_col", oCol, 4'b1110);
      check("rst_key", oKey, 4'h0);
      check("rst_valid", oKeyValid, 1'b0);
      check("rst_enter", oEnter, 1'b0);
      check("rst_digits", {oD4, oD3, oD2, oD1}, 16'h0000);
      @(negedge iClk);
      iRst = 1'b1;

      // Table-driven segments
      foreach (segs[s]) begin
         segPulses = 0;
         segEnters = 0;
         for (int f = 0; f < segs[s].frames; f++) runFrame(segs[s].mask);
         check("seg_pulses", segPulses, segs[s].pulses);
         check("seg_enters", segEnters, segs[s].enters);
         check("seg_key", oKey, segs[s].key);
         check("seg_digits", {oD4, oD3, oD2, oD1}, segs[s].digits);
         $display("seg %0d mask=%h frames=%0d pulses=%0d key=%h digits=%h",
                  s, segs[s].mask, segs[s].frames, segPulses, oKey, {oD4, oD3, oD2, oD1});
      end

      // Reset in the middle of holding '9'
      for (int f = 0; f < 4; f++) runFrame(K9);
      repeat (6) @(posedge iClk);
      #2;
      iRst = 1'b0;
      #1;
      check("midrst_col", oCol, 4'b1110);
      check("midrst_key", oKey, 4'h0);
      check("midrst_valid", oKeyValid, 1'b0);
      check("midrst_digits", {oD4, oD3, oD2, oD1}, 16'h0000);
      modelReset();
      repeat (3) @(posedge iClk);
      @(negedge iClk);
      iRst = 1'b1;
      segPulses = 0;
      segEnters = 0;
      for (int f = 0; f < 2; f++) runFrame(K9);
      check("reaccept_early", segPulses, 0);
      runFrame(K9);
      check("reaccept_pulses", segPulses, 1);
      check("reaccept_key", oKey, 4'h9);
      check("reaccept_digits", {oD4, oD3, oD2, oD1}, 16'h0009);
      $display("reset-hold: key=%h digits=%h", oKey, {oD4, oD3, oD2, oD1});
      for (int f = 0; f < 3; f++) runFrame(KNONE);

      // Randomised key patterns against the reference model
      for (int s = 0; s < 40; s++) begin
         kind = $urandom_range(0, 2);
         nfr  = $urandom_range(1, 5);
         case (kind)
            0: mask = '0;
            1: mask = 16'h0001 << $urandom_range(0, 15);
            default: begin
               a = $urandom_range(0, 15);
               b = (a + $urandom_range(1, 15)) % 16;
               mask = (16'h0001 << a) | (16'h0001 << b);
            end
         endcase
         segPulses = 0;
         segEnters = 0;
         for (int f = 0; f < nfr; f++) runFrame(mask);
         $display("rand %0d mask=%h frames=%0d pulses=%0d key=%h digits=%h",
                  s, mask, nfr, segPulses, oKey, {oD4, oD3, oD2, oD1});
      end
      for (int f = 0; f < 4; f++) runFrame(KNONE);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
